// File: rtl/rop_dcr_commit.sv
// Atomic DCR commit stage: closes fragment intake, drains in-flight work, then publishes staged DCRs.
// Optional stall counter enabled with ROP_DCR_COMMIT_PERF_EN.

package rop_dcr_commit_pkg;
  typedef struct packed {
    logic [31:0] blend_color;
    logic [15:0] blend_func;
    logic [7:0]  depth_func;
    logic [7:0]  stencil_ref;
  } rop_dcrs_t;
endpackage

module rop_dcr_commit
  import rop_dcr_commit_pkg::*;
#(
  parameter int DCRS_BITS    = $bits(rop_dcrs_t),
  parameter int MAX_INFLIGHT = 16,
  parameter int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DCRS_BITS-1:0] staged_dcrs,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic                 frag_in_valid,
  output logic                 frag_in_ready,
  output logic                 frag_out_valid,
  input  logic                 frag_out_ready,
  input  logic                 retire,
  output logic [DCRS_BITS-1:0] active_dcrs,
  output logic [CNTW-1:0]      inflight,
  output logic                 drain_busy,
  output logic [31:0]          stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT
  } state_t;

  state_t          state, state_next;
  logic [CNTW-1:0] inflight_q, inflight_next;
  logic            gate_open;
  logic            fire;
  logic            retire_ok;

  // Gate is held shut while reset is asserted so no handshake leaks out before state is valid.
  assign gate_open      = reset && (state == IDLE) && (inflight_q < CNTW'(MAX_INFLIGHT));
  assign frag_out_valid = frag_in_valid && gate_open;
  assign frag_in_ready  = frag_out_ready && gate_open;
  assign fire           = frag_in_valid && frag_in_ready;
  assign retire_ok      = retire && (inflight_q != '0);

  assign inflight   = inflight_q;
  assign drain_busy = (state != IDLE);

  always_comb begin
    inflight_next = inflight_q;
    if (fire && !retire_ok)
      inflight_next = inflight_q + CNTW'(1);
    else if (!fire && retire_ok)
      inflight_next = inflight_q - CNTW'(1);
  end

  always_comb begin
    state_next   = state;
    commit_ready = 1'b0;
    case (state)
      IDLE: begin
        if (commit_valid)
          state_next = DRAIN;
      end
      DRAIN: begin
        if ((inflight_q == '0) && !retire)
          state_next = COMMIT;
      end
      COMMIT: begin
        commit_ready = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      inflight_q  <= '0;
      active_dcrs <= '0;
    end else begin
      state      <= state_next;
      inflight_q <= inflight_next;
      if (state == COMMIT)
        active_dcrs <= staged_dcrs;
    end
  end

`ifdef ROP_DCR_COMMIT_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (frag_in_valid && !gate_open && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  // A retire with nothing outstanding means the ROP core and this counter disagree.
  assert property (@(posedge clk) disable iff (!reset) !(retire && (inflight_q == '0)))
    else $warning("rop_dcr_commit: retire with no fragments in flight");

endmodule
